// File: rtl/plot_sink_fb_pkg.sv
// plot_sink_fb_pkg: shared game constants, plot/pixel types and addressing helpers
package plot_sink_fb_pkg;
    localparam int H_RES      = 160;
    localparam int V_RES      = 120;
    localparam int X_W        = 8;
    localparam int Y_W        = 7;
    localparam int COLOUR_W   = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int N_PIX      = H_RES * V_RES;
    localparam int ADDR_W     = 15;
    typedef logic [X_W-1:0]      x_t;
    typedef logic [Y_W-1:0]      y_t;
    typedef logic [COLOUR_W-1:0] colour_t;
    typedef logic [ADDR_W-1:0]   addr_t;
    localparam colour_t BLACK = 3'b000;
    localparam colour_t WHITE = 3'b111;
    localparam colour_t WALL  = 3'b110;
    localparam colour_t DUDE  = 3'b010;
    typedef struct packed {
        x_t      x;
        y_t      y;
        colour_t colour;
    } plot_t;
    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
    function automatic logic in_range(x_t x, y_t y);
        return (x < X_W'(H_RES)) && (y < Y_W'(V_RES));
    endfunction
    function automatic addr_t pix_addr(x_t x, y_t y);
        return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
    endfunction
endpackage

// File: rtl/plot_sink_fb_if.sv
// plot_sink_fb_if: plot, clear and pixel-read signals between the game datapath (master) and the framebuffer (slave)
interface plot_sink_fb_if;
    import plot_sink_fb_pkg::*;
    logic    plot;
    x_t      x;
    y_t      y;
    colour_t colour;
    logic    plot_ready;
    logic    clear;
    colour_t clear_colour;
    logic    busy;
    logic    rd_req;
    x_t      rd_x;
    y_t      rd_y;
    logic    rd_ready;
    logic    rd_valid;
    colour_t rd_colour;
    logic    oob_err;
    modport master (
        output plot, x, y, colour, clear, clear_colour, rd_req, rd_x, rd_y,
        input  plot_ready, busy, rd_ready, rd_valid, rd_colour, oob_err
    );
    modport slave (
        input  plot, x, y, colour, clear, clear_colour, rd_req, rd_x, rd_y,
        output plot_ready, busy, rd_ready, rd_valid, rd_colour, oob_err
    );
endinterface

// File: rtl/plot_sink_fb_plot_fifo.sv
// plot_fifo: synchronous FIFO of plot requests; ports clk/resetn, push/din, pop/dout (show-ahead), full/empty/count
module plot_fifo
    import plot_sink_fb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   pop,
    input  plot_t                  din,
    output plot_t                  dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    plot_t mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic do_push, do_pop;
    // a push into a full FIFO is legal when the same cycle pops
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rp];
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + PW'(do_push);
            rp    <= rp + PW'(do_pop);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/plot_sink_fb.sv
// plot_sink_fb: buffered pixel-plot sink into a single-port colour framebuffer with bulk clear and registered read port
// Ports: clk, resetn (async active-low), bus (plot_sink_fb_if.slave: plot/x/y/colour/plot_ready,
//        clear/clear_colour/busy, rd_req/rd_x/rd_y/rd_ready/rd_valid/rd_colour, oob_err)
module plot_sink_fb
    import plot_sink_fb_pkg::*;
(
    input logic          clk,
    input logic          resetn,
    plot_sink_fb_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t  state_q, state_d;
    colour_t mem [N_PIX];
    plot_t   req, head;
    logic    f_full, f_empty;
    logic [CW-1:0] f_count;
    logic    push, pop, we, rd_acc, rd_in, last, clear_acc;
    logic    pending, plot_ready_q, rd_valid_q, oob_q;
    addr_t   addr, clr_addr;
    colour_t wdata, clr_col, rd_col_q;
    assign req       = '{x: bus.x, y: bus.y, colour: bus.colour};
    assign push      = bus.plot && plot_ready_q;
    assign rd_acc    = bus.rd_req && state_q != CLEAR;
    assign rd_in     = in_range(bus.rd_x, bus.rd_y);
    assign last      = clr_addr == ADDR_W'(N_PIX - 1);
    assign clear_acc = bus.clear && !pending && state_q != CLEAR;
    plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .resetn(resetn),
        .push  (push),
        .pop   (pop),
        .din   (req),
        .dout  (head),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= CLEAR;
        else         state_q <= state_d;
    end
    // one RAM port: clear owns it, otherwise an accepted read beats the FIFO pop
    always_comb begin
        state_d = state_q == IDLE  ? (!f_empty ? WRITE : pending ? CLEAR : IDLE) :
                  state_q == WRITE ? (f_empty ? IDLE : WRITE) :
                                     (last ? IDLE : CLEAR);
        pop     = state_q == WRITE && !f_empty && !rd_acc;
        we      = state_q == CLEAR || (pop && in_range(head.x, head.y));
        addr    = state_q == CLEAR ? clr_addr :
                  rd_acc           ? pix_addr(bus.rd_x, bus.rd_y) : pix_addr(head.x, head.y);
        wdata   = state_q == CLEAR ? clr_col : head.colour;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clr_addr     <= '0;
            clr_col      <= BLACK;
            pending      <= 1'b0;
            plot_ready_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_col_q     <= BLACK;
            oob_q        <= 1'b0;
        end else begin
            clr_addr     <= (state_q == CLEAR && !last) ? clr_addr + ADDR_W'(1) : '0;
            pending      <= clear_acc || (pending && state_d != CLEAR);
            if (clear_acc) clr_col <= bus.clear_colour;
            // ready reflects the count after this cycle's push/pop so it never overfills
            plot_ready_q <= (f_count + CW'(push) - CW'(pop)) != CW'(FIFO_DEPTH);
            rd_valid_q   <= rd_acc;
            rd_col_q     <= (rd_acc && rd_in) ? mem[addr] : BLACK;
            oob_q        <= oob_q || (rd_acc && !rd_in) || (pop && !in_range(head.x, head.y));
        end
    end
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
    assign bus.plot_ready = plot_ready_q;
    assign bus.busy       = state_q == CLEAR || !f_empty;
    assign bus.rd_ready   = state_q != CLEAR;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_colour  = rd_col_q;
    assign bus.oob_err    = oob_q;
endmodule

// File: tb/tb_plot_sink_fb.sv
// tb_plot_sink_fb: scoreboard bench for plot_sink_fb with a shadow framebuffer model
module tb_plot_sink_fb;
    import plot_sink_fb_pkg::*;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;
    plot_sink_fb_if bus();
    plot_sink_fb dut (.clk(clk), .resetn(resetn), .bus(bus));
    int total = 0;
    int bad = 0;
    logic [2:0] fb [N_PIX];
    logic [2:0] exp_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] exp_px(int px, int py);
        return (px < H_RES && py < V_RES) ? fb[py*H_RES+px] : 3'd0;
    endfunction

    task automatic fill(logic [2:0] c);
        for (int i = 0; i < N_PIX; i++) fb[i] = c;
    endtask

    task automatic issue_read(int px, int py);
        bus.rd_req = 1'b1;
        bus.rd_x = X_W'(px);
        bus.rd_y = Y_W'(py);
        exp_q.push_back(exp_px(px, py));
        step();
        bus.rd_req = 1'b0;
    endtask

    task automatic take_read(string tag);
        logic [2:0] e;
        e = exp_q.size() > 0 ? exp_q.pop_front() : 3'bxxx;
        total++;
        if (bus.rd_valid !== 1'b1 || bus.rd_colour !== e) begin
            bad++;
            $display("FAIL %s: rd_valid=%b rd_colour=%0d required rd_valid=1 rd_colour=%0d", tag, bus.rd_valid, bus.rd_colour, e);
        end
    endtask

    task automatic read_px(int px, int py, string tag);
        issue_read(px, py);
        take_read(tag);
    endtask

    task automatic plot_px(int px, int py, int c);
        bus.plot = 1'b1;
        bus.x = X_W'(px);
        bus.y = Y_W'(py);
        bus.colour = COLOUR_W'(c);
        step();
        bus.plot = 1'b0;
    endtask

    task automatic wait_busy(string tag, int max, output int n);
        n = 0;
        while (bus.busy !== 1'b0 && n < max) begin
            step();
            n++;
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", tag, bus.busy, n);
        end
    endtask

    task automatic wait_clear_start(string tag);
        int n;
        n = 0;
        while (bus.rd_ready !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (bus.rd_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s: rd_ready=%b, required 0 once clear starts", tag, bus.rd_ready);
        end
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.plot_ready, bus.rd_ready, bus.rd_valid, bus.rd_colour, bus.oob_err, bus.busy} !== 8'b0000_0001) begin
            bad++;
            $display("FAIL reset_state: got %b required 00000001", {bus.plot_ready, bus.rd_ready, bus.rd_valid, bus.rd_colour, bus.oob_err, bus.busy});
        end
        resetn = 1'b1;
        wait_busy("reset_clear", 20000, n);
        total++;
        if (n < 19195 || n > 19210) begin
            bad++;
            $display("FAIL reset_clear_len: %0d cycles required about 19200", n);
        end
        fill(3'd0);
        read_px(5, 5, "read_after_reset");
        step();
        total++;
        if (bus.rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL rd_valid_pulse: rd_valid=%b required 0", bus.rd_valid);
        end
    endtask

    task automatic test_plot();
        int n;
        total++;
        if (bus.plot_ready !== 1'b1) begin
            bad++;
            $display("FAIL plot_ready_idle: %b required 1", bus.plot_ready);
        end
        plot_px(10, 20, 5);
        fb[20*H_RES+10] = 3'd5;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_fifo: busy=%b required 1", bus.busy);
        end
        step();
        step();
        read_px(10, 20, "plot_basic");
        plot_px(11, 20, 6);
        step();
        read_px(11, 20, "read_beats_write");
        fb[20*H_RES+11] = 3'd6;
        wait_busy("plot_drain", 20, n);
        read_px(11, 20, "stalled_write");
    endtask

    task automatic test_back_to_back();
        int n;
        for (int i = 0; i < 6; i++) begin
            bus.plot = 1'b1;
            bus.x = X_W'(30 + i);
            bus.y = Y_W'(40 + i);
            bus.colour = COLOUR_W'(i + 1);
            bus.rd_req = 1'b1;
            bus.rd_x = '0;
            bus.rd_y = '0;
            exp_q.push_back(exp_px(0, 0));
            total++;
            if (bus.plot_ready !== 1'(i < 4)) begin
                bad++;
                $display("FAIL fifo_ready[%0d]: plot_ready=%b required %b", i, bus.plot_ready, 1'(i < 4));
            end
            step();
            take_read("hold_read");
            if (i < 4) fb[(40+i)*H_RES+30+i] = COLOUR_W'(i + 1);
        end
        bus.plot = 1'b0;
        bus.rd_req = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.plot_ready !== 1'b0) begin
            bad++;
            $display("FAIL fifo_held: busy=%b plot_ready=%b required 1 0", bus.busy, bus.plot_ready);
        end
        wait_busy("fifo_drain", 50, n);
        for (int i = 0; i < 6; i++) read_px(30 + i, 40 + i, "fifo_readback");
    endtask

    task automatic test_oob_plot();
        int n;
        total++;
        if (bus.oob_err !== 1'b0) begin
            bad++;
            $display("FAIL oob_pre: oob_err=%b required 0", bus.oob_err);
        end
        plot_px(160, 0, 7);
        wait_busy("oob_drain", 20, n);
        total++;
        if (bus.oob_err !== 1'b1) begin
            bad++;
            $display("FAIL oob_plot: oob_err=%b required 1", bus.oob_err);
        end
        read_px(159, 0, "oob_neighbour");
        read_px(0, 1, "oob_no_wrap");
    endtask

    task automatic test_clear_order();
        int n;
        plot_px(1, 1, 2);
        bus.clear = 1'b1;
        bus.clear_colour = 3'd4;
        step();
        bus.clear_colour = 3'd1;
        step();
        bus.clear = 1'b0;
        wait_clear_start("clear_start");
        fill(3'd4);
        bus.clear = 1'b1;
        bus.clear_colour = 3'd7;
        plot_px(2, 2, 6);
        bus.clear = 1'b0;
        fb[2*H_RES+2] = 3'd6;
        bus.rd_req = 1'b1;
        bus.rd_x = 8'd1;
        bus.rd_y = 7'd1;
        step();
        bus.rd_req = 1'b0;
        total++;
        if (bus.rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL read_in_clear: rd_valid=%b required 0", bus.rd_valid);
        end
        n = 0;
        while (bus.rd_ready !== 1'b1 && n < 20000) begin
            step();
            n++;
        end
        total++;
        if (n + 2 < 19195 || n + 2 > 19210) begin
            bad++;
            $display("FAIL clear_rd_ready_len: %0d cycles required about 19200", n + 2);
        end
        wait_busy("clear_drain", 20, n);
        read_px(1, 1, "clear_over_plot");
        read_px(2, 2, "plot_after_clear");
        read_px(3, 3, "clear_fill");
        read_px(159, 119, "clear_last_pixel");
    endtask

    task automatic test_reset_mid_clear();
        int n;
        bus.clear = 1'b1;
        bus.clear_colour = 3'd7;
        step();
        bus.clear = 1'b0;
        wait_clear_start("mid_clear_start");
        repeat (100) step();
        plot_px(3, 3, 5);
        resetn = 1'b0;
        #2;
        total++;
        if ({bus.rd_valid, bus.busy, bus.plot_ready, bus.rd_ready, bus.rd_colour} !== 7'b0100000) begin
            bad++;
            $display("FAIL async_reset: got %b required 0100000", {bus.rd_valid, bus.busy, bus.plot_ready, bus.rd_ready, bus.rd_colour});
        end
        step();
        resetn = 1'b1;
        fill(3'd0);
        wait_busy("rerun_clear", 20000, n);
        total++;
        if (n < 19195 || n > 19210) begin
            bad++;
            $display("FAIL rerun_clear_len: %0d cycles required about 19200", n);
        end
        read_px(0, 0, "rerun_first");
        read_px(3, 3, "rerun_discarded_plot");
        read_px(10, 20, "rerun_old_plot");
        read_px(159, 119, "rerun_last");
    endtask

    task automatic test_read_oob();
        int n;
        plot_px(40, 6, 3);
        fb[6*H_RES+40] = 3'd3;
        wait_busy("read_oob_drain", 20, n);
        total++;
        if (bus.oob_err !== 1'b0) begin
            bad++;
            $display("FAIL oob_cleared: oob_err=%b required 0", bus.oob_err);
        end
        read_px(40, 6, "alias_target");
        read_px(200, 5, "read_oob_x");
        total++;
        if (bus.oob_err !== 1'b1) begin
            bad++;
            $display("FAIL oob_read: oob_err=%b required 1", bus.oob_err);
        end
        read_px(5, 120, "read_oob_y");
    endtask

    initial begin
        bus.plot = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.colour = '0;
        bus.clear = 1'b0;
        bus.clear_colour = '0;
        bus.rd_req = 1'b0;
        bus.rd_x = '0;
        bus.rd_y = '0;
        test_reset();
        test_plot();
        test_back_to_back();
        test_oob_plot();
        test_clear_order();
        test_reset_mid_clear();
        test_read_oob();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: %0d reads outstanding required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
